spi_xfer_ctrl: RTL and testbench

Master-side byte transfer sequencer for the SPI block. It owns slave select and the 8-bit shift registers. It enables the existing SCLK/flag generator by driving ss low, and advances one bit per flag pulse from that generator. It accepts a TX byte from the APB register side and returns an RX byte with a one-cycle valid strobe. It aborts cleanly when the peripheral is disabled or enters wait mode.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_shift_reg.sv | 57 +++++
 rtl/spi_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer path: FSM encoding,
// spi_mode codes and the default transfer width.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
  localparam logic [1:0] SPI_MODE_WAIT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } xfer_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Bidirectional TX/RX shifter. Bit order is latched at load so that a mid-transfer
// lsbfe change only affects the next byte.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              load_i,
  input  logic              lsbfe_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sample_i,
  input  logic              shift_i,
  input  logic              miso_i,
  output logic [DATA_W-1:0] rx_o,
  output logic              tx_bit_d_o
);

  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              lsb_first_q, lsb_first_d;

  always_comb begin
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    lsb_first_d = lsb_first_q;
    if (load_i) begin
      tx_sh_d     = data_i;
      rx_sh_d     = '0;
      lsb_first_d = lsbfe_i;
    end else begin
      if (shift_i)
        tx_sh_d = lsb_first_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
      if (sample_i)
        rx_sh_d = lsb_first_q ? {miso_i, rx_sh_q[DATA_W-1:1]}
                              : {rx_sh_q[DATA_W-2:0], miso_i};
    end
    // Next line state, so the owner can register mosi in step with tx_sh
    tx_bit_d_o = lsb_first_d ? tx_sh_d[0] : tx_sh_d[DATA_W-1];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      lsb_first_q <= 1'b0;
    end else begin
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      lsb_first_q <= lsb_first_d;
    end
  end

  assign rx_o = rx_sh_q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Master-side SPI byte sequencer: owns ss, steps the shifter on generator
// flag pulses, and reports completion or abort with one-cycle strobes.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int SS_GAP = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              spe_i,
  input  logic              mstr_i,
  input  logic              spiswai_i,
  input  logic [1:0]        spi_mode_i,
  input  logic              lsbfe_i,
  input  logic              send_data_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  input  logic              sample_pulse_i,
  input  logic              shift_pulse_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              ss_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              abort_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

  xfer_state_e       state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              ss_q, mosi_q, busy_q, rx_valid_q, abort_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] rx_sh;
  logic              tx_bit_d;
  logic              go, load, active, smp, shf;

  assign go     = spe_i & mstr_i & ~spiswai_i & (spi_mode_i == SPI_MODE_RUN);
  assign load   = (state_q == ST_IDLE) & send_data_i & go;
  // Pulses stop counting once the last bit is in; DONE follows on the next edge
  assign active = (state_q == ST_XFER) & go & (bit_cnt_q != CNT_FULL);
  assign smp    = active & sample_pulse_i;
  assign shf    = active & shift_pulse_i;

  spi_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .load_i     (load),
    .lsbfe_i    (lsbfe_i),
    .data_i     (tx_data_i),
    .sample_i   (smp),
    .shift_i    (shf),
    .miso_i     (miso_i),
    .rx_o       (rx_sh),
    .tx_bit_d_o (tx_bit_d)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            ss_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            mosi_q    <= tx_bit_d;
            state_q   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!go) begin
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            abort_q   <= 1'b1;
            mosi_q    <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end else if (bit_cnt_q == CNT_FULL) begin
            state_q <= ST_DONE;
          end else begin
            if (smp) bit_cnt_q <= bit_cnt_q + 1'b1;
            mosi_q <= tx_bit_d;
          end
        end
        ST_DONE: begin
          if (!go) begin
            abort_q <= 1'b1;
          end else begin
            rx_data_q  <= rx_sh;
            rx_valid_q <= 1'b1;
          end
          ss_q      <= 1'b1;
          busy_q    <= 1'b0;
          mosi_q    <= 1'b0;
          gap_cnt_q <= '0;
          state_q   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_q <= ST_IDLE;
          else                       gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready_o = (state_q == ST_IDLE) & go;
  assign mosi_o     = mosi_q;
  assign ss_o       = ss_q;
  assign busy_o     = busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign abort_o    = abort_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: the bench plays the flag generator and the slave,
// predicting mosi order and received bytes from the byte values themselves.
module tb_spi_xfer_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       spe, mstr, spiswai, lsbfe, send_data;
  logic [1:0] spi_mode;
  logic [7:0] tx_data;
  logic       tx_ready, sample_pulse, shift_pulse, miso, mosi, ss, busy;
  logic [7:0] rx_data;
  logic       rx_valid, abort;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rx;

  spi_xfer_ctrl #(.DATA_W(8), .SS_GAP(2)) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .spe_i          (spe),
    .mstr_i         (mstr),
    .spiswai_i      (spiswai),
    .spi_mode_i     (spi_mode),
    .lsbfe_i        (lsbfe),
    .send_data_i    (send_data),
    .tx_data_i      (tx_data),
    .tx_ready_o     (tx_ready),
    .sample_pulse_i (sample_pulse),
    .shift_pulse_i  (shift_pulse),
    .miso_i         (miso),
    .mosi_o         (mosi),
    .ss_o           (ss),
    .busy_o         (busy),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .abort_o        (abort)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rxb;
    logic       lsb;
    logic       coinc;
    logic [7:0] exp_mseq;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 30) begin
      tick();
      n++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
  endtask

  // Full transfer: returns the mosi bits in the order they appeared on the line.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] rxb,
                          input logic lsb, input logic coinc, input int gapmax,
                          output logic [7:0] mseq);
    int lat;
    wait_ready();
    tx_data = tx; lsbfe = lsb; send_data = 1'b1;
    tick();
    send_data = 1'b0; tx_data = 8'($urandom);
    chk("ss_load", 32'(ss), 32'd0);
    chk("busy_load", 32'(busy), 32'd1);
    lsbfe = ~lsb;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(gapmax, 0)) tick();
      mseq[7-i] = mosi;
      miso = lsb ? rxb[i] : rxb[7-i];
      sample_pulse = 1'b1; shift_pulse = coinc;
      tick();
      sample_pulse = 1'b0; shift_pulse = 1'b0;
      miso = 1'($urandom);
      if (!coinc && i < 7) begin
        repeat ($urandom_range(gapmax, 0)) tick();
        shift_pulse = 1'b1;
        tick();
        shift_pulse = 1'b0;
      end
    end
    shift_pulse = ~coinc;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      shift_pulse = 1'b0;
      if (k == 1) chk("ss_low_done", 32'(ss), 32'd0);
      if (rx_valid) begin
        lat = k;
        break;
      end
    end
    chk("rx_valid_latency", 32'(lat), 32'd2);
    chk("rx_data", 32'(rx_data), 32'(rxb));
    chk("ss_after_done", 32'(ss), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("no_abort", 32'(abort), 32'd0);
    chk("tx_ready_gap1", 32'(tx_ready), 32'd0);
    tick();
    chk("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
    chk("tx_ready_gap2", 32'(tx_ready), 32'd0);
    tx_data = 8'hFF; send_data = 1'b1;
    tick();
    send_data = 1'b0;
    chk("gap_send_dropped_ss", 32'(ss), 32'd1);
    chk("gap_send_dropped_busy", 32'(busy), 32'd0);
    chk("tx_ready_after_gap", 32'(tx_ready), 32'd1);
    last_rx = rxb;
  endtask

  task automatic start_and_sample3(input logic [7:0] tx);
    wait_ready();
    tx_data = tx; lsbfe = 1'b0; send_data = 1'b1;
    tick();
    send_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      miso = 1'($urandom);
      sample_pulse = 1'b1; shift_pulse = 1'b1;
      tick();
      sample_pulse = 1'b0; shift_pulse = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mseq, tx, rxb, rev;
    logic       lsb, coinc;
    int         vcount;

    vt[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 8'h3C};
    vt[1] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'h3C};
    vt[2] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5, 8'h3C};
    vt[3] = '{8'h01, 8'hC6, 1'b0, 1'b0, 8'h01, 8'hC6};
    vt[4] = '{8'h01, 8'hC6, 1'b1, 1'b1, 8'h80, 8'hC6};
    vt[5] = '{8'h5A, 8'h81, 1'b1, 1'b0, 8'h5A, 8'h81};

    PRESETn = 1'b0; spe = 1'b1; mstr = 1'b1; spiswai = 1'b0; spi_mode = 2'b00;
    lsbfe = 1'b0; send_data = 1'b0; tx_data = '0;
    sample_pulse = 1'b0; shift_pulse = 1'b0; miso = 1'b0;
    last_rx = 8'h00;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);

    // Requests while not enabled must have no effect
    spe = 1'b0;
    tick();
    chk("tx_ready_spe_off", 32'(tx_ready), 32'd0);
    send_data = 1'b1; tx_data = 8'h77;
    tick();
    send_data = 1'b0;
    chk("nogo_ss", 32'(ss), 32'd1);
    chk("nogo_busy", 32'(busy), 32'd0);
    spe = 1'b1; spi_mode = 2'b01;
    tick();
    chk("tx_ready_wait_mode", 32'(tx_ready), 32'd0);
    spi_mode = 2'b00;

    foreach (vt[i]) begin
      run_xfer(vt[i].tx, vt[i].rxb, vt[i].lsb, vt[i].coinc, 1, mseq);
      chk($sformatf("vec%0d_mosi_seq", i), 32'(mseq), 32'(vt[i].exp_mseq));
      chk($sformatf("vec%0d_rx", i), 32'(rx_data), 32'(vt[i].exp_rx));
    end

    // Abort by spiswai after the third sample
    start_and_sample3(8'hC3);
    spiswai = 1'b1;
    tick();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_ss", 32'(ss), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_one_cycle", 32'(abort), 32'd0);
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      if (rx_valid) vcount++;
      tick();
    end
    spiswai = 1'b0;
    chk("abort_no_rx_valid", 32'(vcount), 32'd0);
    chk("abort_rx_kept", 32'(rx_data), 32'(last_rx));
    run_xfer(8'h96, 8'h2B, 1'b0, 1'b1, 0, mseq);
    chk("post_abort_mosi", 32'(mseq), 32'h96);

    // Asynchronous reset in the middle of a transfer
    start_and_sample3(8'h3E);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_ss", 32'(ss), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rx_valid", 32'(rx_valid), 32'd0);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    chk("arst_idle", 32'(tx_ready), 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    run_xfer(8'h5A, 8'hE7, 1'b0, 1'b0, 1, mseq);
    chk("post_reset_mosi", 32'(mseq), 32'h5A);

    // Randomised transfers: line order is the byte itself or its bit reversal
    for (int n = 0; n < 12; n++) begin
      tx = 8'($urandom); rxb = 8'($urandom);
      lsb = 1'($urandom); coinc = 1'($urandom);
      rev = {<<{tx}};
      run_xfer(tx, rxb, lsb, coinc, 2, mseq);
      chk($sformatf("rand%0d_mosi_seq", n), 32'(mseq), 32'(lsb ? rev : tx));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
